// File: rtl/mem_if_pkg.sv
// Shared types and constants for the core-to-Avalon memory master.
//   size_t  : access size encoding carried on req_size
//   state_t : bus-master FSM states
//   BE_*    : Avalon byteenable patterns
package mem_if_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the memory master (purely combinational).
//   size, addr_lo, sign_ext : access descriptor (addr_lo = byte offset in word)
//   wdata                   : right-justified store data
//   readdata                : raw Avalon read word
//   be_c                    : lanes touched by the access
//   wdata_c                 : store data replicated onto every lane it may occupy
//   rdata_c                 : addressed lane(s) right-justified and extended
//   misalign_c              : misaligned access or reserved size
module mem_lane_align
  import mem_if_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] readdata,
  output logic [3:0]  be_c,
  output logic [31:0] wdata_c,
  output logic [31:0] rdata_c,
  output logic        misalign_c
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Lane selection for sub-word loads
  always_comb begin
    case (addr_lo)
      2'd0:    rd_byte = readdata[7:0];
      2'd1:    rd_byte = readdata[15:8];
      2'd2:    rd_byte = readdata[23:16];
      default: rd_byte = readdata[31:24];
    endcase
    rd_half = addr_lo[1] ? readdata[31:16] : readdata[15:0];
  end

  // Per-size steering, extension and alignment check
  always_comb begin
    be_c       = '0;
    wdata_c    = wdata;
    rdata_c    = readdata;
    misalign_c = 1'b0;
    case (size_t'(size))
      SZ_BYTE: begin
        be_c    = BE_BYTE0 << addr_lo;
        wdata_c = {4{wdata[7:0]}};
        rdata_c = {{24{sign_ext & rd_byte[7]}}, rd_byte};
      end
      SZ_HALF: begin
        be_c       = addr_lo[1] ? BE_HI_HALF : BE_LO_HALF;
        wdata_c    = {2{wdata[15:0]}};
        rdata_c    = {{16{sign_ext & rd_half[15]}}, rd_half};
        misalign_c = addr_lo[0];
      end
      SZ_WORD: begin
        be_c       = BE_WORD;
        misalign_c = |addr_lo;
      end
      default: misalign_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/avalon_mem_master.sv
// Core-to-Avalon-MM bus master: one outstanding request, word-aligned bus
// cycles, lane steering, load extension, misalign and timeout errors.
//   clk, reset                 : clock, async active-high reset
//   req_*                      : core request (accepted only while req_ready)
//   resp_valid/rdata/err       : one-cycle response per accepted request
//   address/read/write/...     : registered Avalon-MM master signals
//   waitrequest, readdata      : Avalon-MM slave inputs
module avalon_mem_master
  import mem_if_pkg::*;
#(
  parameter int unsigned MAX_WAIT   = 255,
  parameter int unsigned WAIT_CNT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_CNT = WAIT_CNT_W'(MAX_WAIT);

  state_t                 state_q, state_d;
  logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic                   req_ready_q, req_ready_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [31:0]            resp_rdata_q, resp_rdata_d;
  logic                   resp_err_q, resp_err_d;
  logic [31:0]            address_q, address_d;
  logic                   read_q, read_d;
  logic                   write_q, write_d;
  logic [31:0]            writedata_q, writedata_d;
  logic [3:0]             byteenable_q, byteenable_d;
  logic [1:0]             size_q, size_d;
  logic [1:0]             off_q, off_d;
  logic                   sign_q, sign_d;

  logic [1:0]  la_size;
  logic [1:0]  la_off;
  logic        la_sign;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] rdata_c;
  logic        misalign_c;

  // One aligner serves both phases: live request in IDLE, captured request in BUS
  assign la_size = (state_q == BUS) ? size_q : req_size;
  assign la_off  = (state_q == BUS) ? off_q  : req_addr[1:0];
  assign la_sign = (state_q == BUS) ? sign_q : req_signed;

  mem_lane_align u_align (
    .size       (la_size),
    .addr_lo    (la_off),
    .sign_ext   (la_sign),
    .wdata      (req_wdata),
    .readdata   (readdata),
    .be_c       (be_c),
    .wdata_c    (wdata_c),
    .rdata_c    (rdata_c),
    .misalign_c (misalign_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    address_d    = address_q;
    read_d       = read_q;
    write_d      = write_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    size_d       = size_q;
    off_d        = off_q;
    sign_d       = sign_q;

    case (state_q)
      IDLE: begin
        wait_cnt_d = '0;
        if (req_valid) begin
          size_d = req_size;
          off_d  = req_addr[1:0];
          sign_d = req_signed;
          if (misalign_c) begin
            // Rejected without touching the bus
            state_d      = DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d      = BUS;
            address_d    = {req_addr[31:2], 2'b00};
            read_d       = ~req_write;
            write_d      = req_write;
            writedata_d  = wdata_c;
            byteenable_d = be_c;
          end
        end
      end
      BUS: begin
        if (!waitrequest) begin
          state_d      = DONE;
          read_d       = 1'b0;
          write_d      = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = read_q ? rdata_c : '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
          // Watchdog: abandon the transfer after MAX_WAIT stalled edges
          if ((MAX_WAIT != 0) && (wait_cnt_d == MAX_WAIT_CNT)) begin
            state_d      = DONE;
            read_d       = 1'b0;
            write_d      = 1'b0;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      address_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      size_q       <= '0;
      off_q        <= '0;
      sign_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      address_q    <= address_d;
      read_q       <= read_d;
      write_q      <= write_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      size_q       <= size_d;
      off_q        <= off_d;
      sign_q       <= sign_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;

endmodule
